axi4_lite_reg_slave: RTL and testbench
======================================

# axi4_lite_reg_slave

Parametrised AXI4-Lite slave terminating the bus in a register file of NUM_REGS words, DATA_WIDTH bits each. It adds WSTRB byte enables, BRESP/RRESP error reporting, and independent acceptance of write address and write data. It sits behind the bus interface as the reusable endpoint for control/status register banks.

## Interface
- ADDR_WIDTH, 32: AWADDR/ARADDR width.
- DATA_WIDTH, 32: data width; 32 or 64 only.
- NUM_REGS, 16: register count; power of two, ≥2.
- ACLK  in  1  system clock; all state updates on the rising edge.
- ARESETN  in  1  reset; asynchronous, active-low.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte-lane enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response; 00 OKAY, 10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  master accepts the write response.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response; same encoding as BRESP.
- RVALID  out  1  read data valid.
- RREADY  in  1  master accepts read data.

## Operation
- Byte offset bits: OB = log2(DATA_WIDTH/8). Register index: IDX = ADDR[OB+log2(NUM_REGS)-1 : OB].
- Address decode:
  - Any set bit in ADDR above the index field means out of range. Response is SLVERR, writes have no effect, and RDATA = 0.
  - Low OB bits are ignored.
- Write path:
  - AW and W are captured into separate holding registers, each with its own held flag. Either may arrive first, or both may arrive in the same cycle.
  - AWREADY = ARESETN & !aw_held & !BVALID.
  - WREADY = ARESETN & !w_held & !BVALID.
  - Commit happens on the edge where both flags are set. Each byte lane i with WSTRB[i]=1 is written, other lanes keep their value. BVALID is set and BRESP is loaded, and both held flags are cleared on that same edge.
  - A write with WSTRB = 0 is a no-op that still returns OKAY.
  - BVALID and BRESP stay stable until the BVALID & BREADY edge, which clears BVALID.
- Read path:
  - ARREADY = ARESETN & !RVALID.
  - On the ARVALID & ARREADY edge, RDATA, RRESP and RVALID=1 are registered.
  - RDATA and RRESP stay stable until the RVALID & RREADY edge, which clears RVALID.
- Read and write paths are fully independent.
- Read/write collision on the same register: if the AR handshake edge is also the write-commit edge, RDATA returns the pre-write value.
- Reset (asynchronous, any time, including mid-transaction):
  - Registers: all registers = 0. Held flags are cleared and any pending transaction is dropped.
  - Outputs: BVALID = RVALID = 0, BRESP = RRESP = 00, RDATA = 0, and all READY outputs = 0 while ARESETN is low.
  - After release, AWREADY = WREADY = ARREADY = 1.

## Timing
- Write response: BVALID rises 1 edge after the later of the AW and W handshakes, or after the simultaneous handshake. With BREADY tied high, the next AW/W is accepted 2 cycles after the previous one.
- Read: RVALID rises 1 edge after the AR handshake. With RREADY tied high, reads sustain one per 2 cycles.
- Backpressure: BREADY or RREADY low stalls that path indefinitely, with outputs held stable; the other path is unaffected.
- No combinational path from any VALID input to any READY output.

## Test plan
- Reset read: after reset, read address 0x04 -> RDATA = 0x00000000, RRESP = 00, RVALID one edge after the AR handshake.
- Full write then read:
  - Write 0xDEADBEEF to 0x08 with WSTRB = 1111 and AW/W in the same cycle -> BVALID next edge, BRESP = 00.
  - Read 0x08 -> 0xDEADBEEF.
- Partial strobe and skewed channels:
  - Send W first (WSTRB = 0101, WDATA = 0x11223344) to a register holding 0xDEADBEEF, then AW (0x08) 3 cycles later.
  - AWREADY and WREADY remain 1 until their own handshake. BVALID rises 1 edge after AW.
  - Readback = 0xDE22BE44.
- Out of range (NUM_REGS = 16, DATA_WIDTH = 32):
  - Write to 0x40 -> BRESP = 10, register file unchanged.
  - Read 0x40 -> RRESP = 10, RDATA = 0.
- Backpressure:
  - Hold BREADY = 0 for 5 cycles -> BVALID and BRESP stable, AWREADY = WREADY = 0 throughout.
  - Concurrently a read completes normally.
- Reset mid-operation:
  - Assert ARESETN low while aw_held = 1 and RVALID = 1 -> RVALID = 0 immediately, all READY = 0.
  - After release, a lone W does not commit until a new AW arrives.

Source files
------------

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave that ends the bus in a flat register file.
// AW and W are captured independently. The write commits on the edge where
// both are present. Byte lanes are written under WSTRB, and any address bit
// above the register index gives SLVERR. Reads take one handshake and then
// hold RDATA/RRESP until RREADY.
//
// Ports:
//   ACLK, ARESETN                  clock, async active-low reset
//   AWADDR/AWVALID/AWREADY         write address channel
//   WDATA/WSTRB/WVALID/WREADY      write data channel
//   BRESP/BVALID/BREADY            write response channel (00 OKAY, 10 SLVERR)
//   ARADDR/ARVALID/ARREADY         read address channel
//   RDATA/RRESP/RVALID/RREADY      read data channel
`timescale 1ns/1ps
module axi4_lite_reg_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OB         = $clog2(STRB_WIDTH);
   localparam int IW         = $clog2(NUM_REGS);
   localparam int TOP        = OB + IW;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  aw_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic                  w_held;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  commit;

   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic [IW-1:0]         wr_idx;
   logic [IW-1:0]         rd_idx;
   logic                  wr_oor;
   logic                  rd_oor;

   // The byte-offset bits of both addresses are don't-care.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{wr_addr[OB-1:0], ARADDR[OB-1:0]};

   // READY depends only on registered state. This keeps any VALID-to-READY
   // combinational loop out of the master.
   assign AWREADY = ARESETN & ~aw_held & ~BVALID;
   assign WREADY  = ARESETN & ~w_held  & ~BVALID;
   assign ARREADY = ARESETN & ~RVALID;

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID  & WREADY;
   assign ar_hs = ARVALID & ARREADY;

   // Commit on the edge where the second half arrives, or on the edge where
   // both halves arrive together. The half that is not yet held comes from
   // the bus directly.
   assign commit  = (aw_held | aw_hs) & (w_held | w_hs);
   assign wr_addr = aw_held ? aw_addr_q : AWADDR;
   assign wr_data = w_held  ? w_data_q  : WDATA;
   assign wr_strb = w_held  ? w_strb_q  : WSTRB;

   assign wr_idx = wr_addr[TOP-1:OB];
   assign rd_idx = ARADDR[TOP-1:OB];
   assign wr_oor = |(wr_addr >> TOP);
   assign rd_oor = |(ARADDR  >> TOP);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_held   <= 1'b0;
         aw_addr_q <= '0;
         w_held    <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) aw_addr_q <= AWADDR;
         if (w_hs) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
         end
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end else begin
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs)  w_held  <= 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         BVALID <= 1'b0;
         BRESP  <= RESP_OKAY;
      end else if (commit) begin
         BVALID <= 1'b1;
         BRESP  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (BVALID && BREADY) begin
         BVALID <= 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (commit && !wr_oor) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (wr_strb[i]) regs[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // A read that lands on the commit edge samples regs before the
   // non-blocking write, so it returns the pre-write value.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         RVALID <= 1'b0;
         RRESP  <= RESP_OKAY;
         RDATA  <= '0;
      end else if (ar_hs) begin
         RVALID <= 1'b1;
         RRESP  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
         RDATA  <= rd_oor ? '0 : regs[rd_idx];
      end else if (RVALID && RREADY) begin
         RVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
`timescale 1ns/1ps
module tb_axi4_lite_reg_slave;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] AWADDR = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b1;
   logic [31:0] ARADDR = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY = 1'b1;

   axi4_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   int tests = 0;
   int fails = 0;

   // Reference model: 16 words, byte address / 4 selects the word,
   // anything at or above 0x40 is an error.
   logic [31:0] mdl [16];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mdl_clear();
      for (int r = 0; r < 16; r++) mdl[r] = '0;
   endtask

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      if (a >= 32'h40) begin
         resp = 2'b10;
      end else begin
         resp = 2'b00;
         for (int i = 0; i < 4; i++)
            if (s[i]) mdl[a / 4][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   task automatic mdl_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      if (a >= 32'h40) begin
         d = '0;
         resp = 2'b10;
      end else begin
         d = mdl[a / 4];
         resp = 2'b00;
      end
   endtask

   // AW is presented aw_dly cycles in and W is presented w_dly cycles in.
   // The task returns at the negedge after the commit edge.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
      int c;
      bit aw_done, w_done, aw_go, w_go;
      c = 0; aw_done = 0; w_done = 0;
      @(negedge ACLK);
      while (!(aw_done && w_done) && c < 30) begin
         if (!aw_done && c == aw_dly) begin AWADDR = a; AWVALID = 1'b1; end
         if (!w_done && c == w_dly) begin WDATA = d; WSTRB = s; WVALID = 1'b1; end
         aw_go = AWVALID && AWREADY;
         w_go  = WVALID && WREADY;
         @(negedge ACLK);
         c++;
         if (aw_go) begin aw_done = 1; AWVALID = 1'b0; end
         if (w_go)  begin w_done = 1;  WVALID = 1'b0;  end
      end
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      chk("write_handshake", {31'd0, aw_done && w_done}, 32'd1);
      chk("bvalid_after_commit", {31'd0, BVALID}, 32'd1);
      resp = BRESP;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int c;
      bit done, go;
      c = 0; done = 0;
      @(negedge ACLK);
      ARADDR = a; ARVALID = 1'b1;
      while (!done && c < 30) begin
         go = ARVALID && ARREADY;
         @(negedge ACLK);
         c++;
         if (go) begin done = 1; ARVALID = 1'b0; end
      end
      ARVALID = 1'b0;
      chk("ar_handshake", {31'd0, done}, 32'd1);
      chk("rvalid_after_ar", {31'd0, RVALID}, 32'd1);
      d = RDATA;
      resp = RRESP;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp, eresp;
      logic [31:0] rd, erd;
      logic [31:0] a;

      vecs[0]  = '{0, 32'h04,        32'h0,        4'h0, 2'b00, 32'h0};
      vecs[1]  = '{1, 32'h08,        32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
      vecs[2]  = '{0, 32'h08,        32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
      vecs[3]  = '{1, 32'h40,        32'h12345678, 4'hF, 2'b10, 32'h0};
      vecs[4]  = '{0, 32'h40,        32'h0,        4'h0, 2'b10, 32'h0};
      vecs[5]  = '{0, 32'h00,        32'h0,        4'h0, 2'b00, 32'h0};
      vecs[6]  = '{1, 32'h0C,        32'hAABBCCDD, 4'h0, 2'b00, 32'h0};
      vecs[7]  = '{0, 32'h0C,        32'h0,        4'h0, 2'b00, 32'h0};
      vecs[8]  = '{1, 32'h0F,        32'h01020304, 4'hF, 2'b00, 32'h0};
      vecs[9]  = '{0, 32'h0C,        32'h0,        4'h0, 2'b00, 32'h01020304};
      vecs[10] = '{1, 32'h3C,        32'hCAFEF00D, 4'hC, 2'b00, 32'h0};
      vecs[11] = '{0, 32'h3C,        32'h0,        4'h0, 2'b00, 32'hCAFE0000};
      vecs[12] = '{0, 32'h10000000,  32'h0,        4'h0, 2'b10, 32'h0};

      mdl_clear();

      // reset state
      #1;
      chk("rst_awready", {31'd0, AWREADY}, 32'd0);
      chk("rst_wready",  {31'd0, WREADY},  32'd0);
      chk("rst_arready", {31'd0, ARREADY}, 32'd0);
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      #1;
      chk("post_rst_awready", {31'd0, AWREADY}, 32'd1);
      chk("post_rst_wready",  {31'd0, WREADY},  32'd1);
      chk("post_rst_arready", {31'd0, ARREADY}, 32'd1);
      chk("post_rst_bvalid",  {31'd0, BVALID},  32'd0);
      chk("post_rst_rvalid",  {31'd0, RVALID},  32'd0);
      chk("post_rst_rdata",   RDATA,            32'd0);

      // directed vector table
      for (int v = 0; v < 13; v++) begin
         if (vecs[v].wr) begin
            axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, 0, 0, resp);
            mdl_write(vecs[v].addr, vecs[v].data, vecs[v].strb, eresp);
            chk($sformatf("vec%0d_bresp", v), {30'd0, resp}, {30'd0, vecs[v].exp_resp});
         end else begin
            axi_read(vecs[v].addr, rd, resp);
            chk($sformatf("vec%0d_rresp", v), {30'd0, resp}, {30'd0, vecs[v].exp_resp});
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
         end
      end

      // restore 0x08 = DEADBEEF, then W first with AW three cycles later
      axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, resp);
      mdl_write(32'h08, 32'hDEADBEEF, 4'hF, eresp);
      @(negedge ACLK);
      WDATA = 32'h11223344; WSTRB = 4'h5; WVALID = 1'b1;
      chk("skew_wready_pre", {31'd0, WREADY}, 32'd1);
      @(negedge ACLK);
      WVALID = 1'b0;
      chk("skew_wready_held", {31'd0, WREADY}, 32'd0);
      chk("skew_awready_c1", {31'd0, AWREADY}, 32'd1);
      @(negedge ACLK);
      chk("skew_awready_c2", {31'd0, AWREADY}, 32'd1);
      chk("skew_no_bvalid", {31'd0, BVALID}, 32'd0);
      @(negedge ACLK);
      AWADDR = 32'h08; AWVALID = 1'b1;
      chk("skew_awready_c3", {31'd0, AWREADY}, 32'd1);
      @(negedge ACLK);
      AWVALID = 1'b0;
      chk("skew_bvalid", {31'd0, BVALID}, 32'd1);
      chk("skew_bresp", {30'd0, BRESP}, 32'd0);
      mdl_write(32'h08, 32'h11223344, 4'h5, eresp);
      axi_read(32'h08, rd, resp);
      chk("skew_readback", rd, 32'hDE22BE44);

      // read/write collision on the same edge returns the old value
      axi_write(32'h20, 32'hA5A5A5A5, 4'hF, 0, 0, resp);
      mdl_write(32'h20, 32'hA5A5A5A5, 4'hF, eresp);
      @(negedge ACLK);
      AWADDR = 32'h20; AWVALID = 1'b1; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; WVALID = 1'b1;
      ARADDR = 32'h20; ARVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      chk("coll_rvalid", {31'd0, RVALID}, 32'd1);
      chk("coll_bvalid", {31'd0, BVALID}, 32'd1);
      chk("coll_rdata_old", RDATA, 32'hA5A5A5A5);
      mdl_write(32'h20, 32'h5A5A5A5A, 4'hF, eresp);
      axi_read(32'h20, rd, resp);
      mdl_read(32'h20, erd, eresp);
      chk("coll_rdata_new", rd, erd);

      // B backpressure with a concurrent read
      @(negedge ACLK);
      BREADY = 1'b0;
      AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0;
      chk("bp_bvalid_start", {31'd0, BVALID}, 32'd1);
      mdl_write(32'h10, 32'h0BADF00D, 4'hF, eresp);
      ARADDR = 32'h10; ARVALID = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge ACLK);
         if (k == 0) begin
            ARVALID = 1'b0;
            chk("bp_read_rvalid", {31'd0, RVALID}, 32'd1);
            chk("bp_read_rdata", RDATA, 32'h0BADF00D);
         end
         chk($sformatf("bp_bvalid_%0d", k), {31'd0, BVALID}, 32'd1);
         chk($sformatf("bp_bresp_%0d", k), {30'd0, BRESP}, 32'd0);
         chk($sformatf("bp_awready_%0d", k), {31'd0, AWREADY}, 32'd0);
         chk($sformatf("bp_wready_%0d", k), {31'd0, WREADY}, 32'd0);
      end
      BREADY = 1'b1;
      @(negedge ACLK);
      chk("bp_bvalid_clear", {31'd0, BVALID}, 32'd0);
      chk("bp_awready_back", {31'd0, AWREADY}, 32'd1);

      // randomized traffic against the model
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 7) == 0) a = 32'h40 + $urandom_range(0, 255);
         else a = $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) begin
            logic [31:0] d;
            logic [3:0]  s;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), resp);
            mdl_write(a, d, s, eresp);
            chk($sformatf("rnd%0d_bresp a=%h", n, a), {30'd0, resp}, {30'd0, eresp});
         end else begin
            axi_read(a, rd, resp);
            mdl_read(a, erd, eresp);
            chk($sformatf("rnd%0d_rresp a=%h", n, a), {30'd0, resp}, {30'd0, eresp});
            chk($sformatf("rnd%0d_rdata a=%h", n, a), rd, erd);
         end
      end

      // reset while an AW is held and a read response is pending
      @(negedge ACLK);
      RREADY = 1'b0;
      AWADDR = 32'h14; AWVALID = 1'b1;
      ARADDR = 32'h08; ARVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; ARVALID = 1'b0;
      chk("mid_rvalid_pre", {31'd0, RVALID}, 32'd1);
      chk("mid_awready_held", {31'd0, AWREADY}, 32'd0);
      #2;
      ARESETN = 1'b0;
      #1;
      chk("mid_rvalid_rst", {31'd0, RVALID}, 32'd0);
      chk("mid_awready_rst", {31'd0, AWREADY}, 32'd0);
      chk("mid_wready_rst", {31'd0, WREADY}, 32'd0);
      chk("mid_arready_rst", {31'd0, ARREADY}, 32'd0);
      chk("mid_rdata_rst", RDATA, 32'd0);
      mdl_clear();
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      RREADY = 1'b1;
      #1;
      chk("mid_arready_rel", {31'd0, ARREADY}, 32'd1);
      @(negedge ACLK);
      WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
      @(negedge ACLK);
      WVALID = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK);
         chk($sformatf("lone_w_no_commit_%0d", k), {31'd0, BVALID}, 32'd0);
      end
      AWADDR = 32'h18; AWVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0;
      chk("lone_w_commit", {31'd0, BVALID}, 32'd1);
      mdl_write(32'h18, 32'hFFFFFFFF, 4'hF, eresp);
      axi_read(32'h18, rd, resp);
      mdl_read(32'h18, erd, eresp);
      chk("after_rst_0x18", rd, erd);
      axi_read(32'h14, rd, resp);
      chk("after_rst_0x14", rd, 32'h0);
      axi_read(32'h08, rd, resp);
      chk("after_rst_0x08", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
